// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: request/ready/exception handshake between a datapath
// controller (master) and the sequential multiplier (slave).
// It carries the operands, the 2N-bit product and the status flags.
`timescale 1ns/1ps

interface seq_multiplier_if #(
  parameter int N = 16
);
  logic           req;
  logic [N-1:0]   Multiplicand;
  logic [N-1:0]   Multiplier;
  logic [2*N-1:0] P;
  logic           ready;
  logic           exception;
  logic           busy;

  // Controller side: issues requests and consumes results.
  modport master (
    output req, Multiplicand, Multiplier,
    input  P, ready, exception, busy
  );

  // Multiplier side: accepts requests and returns results.
  modport slave (
    input  req, Multiplicand, Multiplier,
    output P, ready, exception, busy
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-and-add unsigned multiplier.
// Each cycle in CALC retires one multiplier bit. It returns the full 2N-bit
// product. exception flags a product whose upper half is non-zero.
// It shares the request/ready handshake of the divider.
// Optional build macro MUL_EARLY_EXIT_EN: the operation finishes as soon as
// no set multiplier bits remain. The result is unchanged; only the latency
// shrinks.
`timescale 1ns/1ps

module seq_multiplier #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rstn,
  seq_multiplier_if.slave   bus
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state_reg;
  logic [2*N-1:0]   mc_reg;     // shifted multiplicand, zero-extended to 2N
  logic [N-1:0]     mr_reg;     // remaining multiplier bits, LSB next
  logic [2*N-1:0]   acc_reg;    // running partial sum
  logic [CW-1:0]    cnt_reg;    // bits retired so far
  logic [2*N-1:0]   p_reg;
  logic             ready_reg;
  logic             exc_reg;
  logic             busy_reg;

  logic [2*N-1:0]   addend;
  logic [2*N-1:0]   acc_next;
  logic             last;

  // Partial product for this step: the multiplicand gated by the current
  // multiplier bit.
  generate
    for (genvar gi = 0; gi < 2*N; gi++) begin : g_addend
      assign addend[gi] = mc_reg[gi] & mr_reg[0];
    end
  endgenerate

  // The 2N-bit accumulator cannot overflow, because the product of two
  // N-bit values fits in 2N bits.
  assign acc_next = acc_reg + addend;

  // Terminal condition. The last step is the one whose add completes the
  // product. This step's add is folded into P through acc_next.
`ifdef MUL_EARLY_EXIT_EN
  assign last = ((mr_reg >> 1) == '0) || (cnt_reg == CW'(N - 1));
`else
  assign last = (cnt_reg == CW'(N - 1));
`endif

  // Control FSM and datapath. ready is a one-cycle pulse. P and exception
  // change only on completion or reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      mc_reg    <= '0;
      mr_reg    <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      p_reg     <= '0;
      ready_reg <= 1'b0;
      exc_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            mc_reg    <= {{N{1'b0}}, bus.Multiplicand};
            mr_reg    <= bus.Multiplier;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          mc_reg  <= mc_reg << 1;
          mr_reg  <= mr_reg >> 1;
          cnt_reg <= cnt_reg + CW'(1);
          if (last) begin
            p_reg     <= acc_next;
            exc_reg   <= |acc_next[2*N-1:N];
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.P         = p_reg;
  assign bus.ready     = ready_reg;
  assign bus.exception = exc_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: self-checking bench for seq_multiplier (N=16).
// The reference model is plain integer multiplication plus a latency rule
// derived from the multiplier's most significant set bit.
`timescale 1ns/1ps

module tb_seq_multiplier;

  localparam int N = 16;
  localparam int BUDGET = 100;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_fail;

  seq_multiplier_if #(.N(N)) bus ();

  seq_multiplier #(.N(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected edges from acceptance to completion.
  function automatic int model_lat(input logic [N-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < N; i++) if (b[i]) msb = i;
    return (msb + 1 < 1) ? 1 : msb + 1;
`else
    return N;
`endif
  endfunction

  // Launch one operation and wait (bounded) for ready.
  // Returns with the bench at the negedge inside the ready cycle.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [2*N-1:0] p, output logic exc,
                       output int lat, output logic busy_after_accept);
    @(negedge clk);
    bus.req = 1'b1; bus.Multiplicand = a; bus.Multiplier = b;
    @(posedge clk); #1;
    bus.req = 1'b0;
    busy_after_accept = bus.busy;
    lat = -1;
    for (int i = 0; i <= BUDGET; i++) begin
      @(negedge clk);
      if (bus.ready) begin lat = i; break; end
    end
    p = bus.P; exc = bus.exception;
    $display("op %0d x %0d -> P=%0d exc=%0b lat=%0d", a, b, p, exc, lat);
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.req = 1'b0; bus.Multiplicand = '0; bus.Multiplier = '0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (bus.P !== '0) begin n_fail++; $display("FAIL reset_P got %h want 0", bus.P); end
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    if (bus.exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b want 0", bus.exception); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [N-1:0] av [5] = '{16'd300, 16'd300, 16'hFFFF, 16'd7, 16'd1};
    logic [N-1:0] bv [5] = '{16'd200, 16'd300, 16'hFFFF, 16'd0, 16'd1};
    logic [2*N-1:0] p, pe;
    logic exc, ee, bz;
    int lat;
    for (int k = 0; k < 5; k++) begin
      do_op(av[k], bv[k], p, exc, lat, bz);
      pe = 32'(av[k]) * 32'(bv[k]);
      ee = (pe[2*N-1:N] != 0);
      n_cmp += 5;
      if (p !== pe) begin n_fail++; $display("FAIL dir_P[%0d] got %h want %h", k, p, pe); end
      if (exc !== ee) begin n_fail++; $display("FAIL dir_exc[%0d] got %b want %b", k, exc, ee); end
      if (lat !== model_lat(bv[k])) begin n_fail++; $display("FAIL dir_lat[%0d] got %0d want %0d", k, lat, model_lat(bv[k])); end
      if (bz !== 1'b1) begin n_fail++; $display("FAIL dir_busy[%0d] got %b want 1", k, bz); end
      @(negedge clk);
      if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL dir_pulse[%0d] got %b want 0", k, bus.ready); end
      // Result must hold while idle.
      repeat (3) @(negedge clk);
      n_cmp += 1;
      if (bus.P !== pe) begin n_fail++; $display("FAIL dir_hold[%0d] got %h want %h", k, bus.P, pe); end
    end
  endtask

  task automatic test_latency();
    logic [N-1:0] bv [2] = '{16'd5, 16'd0};
    logic [2*N-1:0] p;
    logic exc, bz;
    int lat;
    for (int k = 0; k < 2; k++) begin
      do_op(16'd1000, bv[k], p, exc, lat, bz);
      n_cmp += 2;
      if (p !== 32'd1000 * 32'(bv[k])) begin n_fail++; $display("FAIL lat_P[%0d] got %0d want %0d", k, p, 32'd1000 * 32'(bv[k])); end
      if (lat !== model_lat(bv[k])) begin n_fail++; $display("FAIL lat_edges[%0d] got %0d want %0d", k, lat, model_lat(bv[k])); end
    end
    @(negedge clk);
  endtask

  task automatic test_req_while_busy();
    int readies, k1, k2;
    logic bz1, bz2;
`ifdef MUL_EARLY_EXIT_EN
    k1 = 2; k2 = 4;
`else
    k1 = 3; k2 = 8;
`endif
    readies = 0; bz1 = 1'b0; bz2 = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.Multiplicand = 16'd5; bus.Multiplier = 16'd9;
    @(posedge clk); #1;
    bus.req = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (bus.ready) readies++;
      if (c == k1) bz1 = bus.busy;
      if (c == k2) bz2 = bus.busy;
      if (c + 1 == k1 || c + 1 == k2) begin
        bus.req = 1'b1; bus.Multiplicand = 16'd200; bus.Multiplier = 16'd200;
      end else begin
        bus.req = 1'b0;
      end
    end
    $display("busy-req op 5 x 9 -> P=%0d readies=%0d", bus.P, readies);
    n_cmp += 5;
    if (readies !== 1) begin n_fail++; $display("FAIL busyreq_readies got %0d want 1", readies); end
    if (bus.P !== 32'd45) begin n_fail++; $display("FAIL busyreq_P got %0d want 45", bus.P); end
    if (bus.exception !== 1'b0) begin n_fail++; $display("FAIL busyreq_exc got %b want 0", bus.exception); end
    if (bz1 !== 1'b1) begin n_fail++; $display("FAIL busyreq_busy1 got %b want 1", bz1); end
    if (bz2 !== 1'b1) begin n_fail++; $display("FAIL busyreq_busy2 got %b want 1", bz2); end
  endtask

  task automatic test_midop_reset();
    int readies;
    logic [2*N-1:0] p;
    logic exc, bz;
    int lat;
    @(negedge clk);
    bus.req = 1'b1; bus.Multiplicand = 16'd1234; bus.Multiplier = 16'd4321;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp += 3;
    if (bus.P !== '0) begin n_fail++; $display("FAIL midrst_P got %h want 0", bus.P); end
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b want 0", bus.ready); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    @(negedge clk);
    rstn = 1'b1;
    readies = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready) readies++;
    end
    $display("mid-op reset 1234 x 4321 -> readies after reset=%0d", readies);
    n_cmp += 1;
    if (readies !== 0) begin n_fail++; $display("FAIL midrst_noready got %0d want 0", readies); end
    do_op(16'd2, 16'd3, p, exc, lat, bz);
    n_cmp += 1;
    if (p !== 32'd6) begin n_fail++; $display("FAIL midrst_next got %0d want 6", p); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b;
    logic [2*N-1:0] p, pe;
    logic exc, bz;
    int lat;
    do_op(16'd11, 16'd13, p, exc, lat, bz);
    for (int k = 0; k < 4; k++) begin
      // Still inside the ready cycle: a held request starts the next op.
      a = 16'($urandom); b = 16'($urandom);
      bus.req = 1'b1; bus.Multiplicand = a; bus.Multiplier = b;
      @(posedge clk); #1;
      bus.req = 1'b0;
      bz = bus.busy;
      lat = -1;
      for (int i = 0; i <= BUDGET; i++) begin
        @(negedge clk);
        if (bus.ready) begin lat = i; break; end
      end
      pe = 32'(a) * 32'(b);
      $display("b2b op %0d x %0d -> P=%0d lat=%0d", a, b, bus.P, lat);
      n_cmp += 4;
      if (bz !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d] got %b want 1", k, bz); end
      if (lat !== model_lat(b)) begin n_fail++; $display("FAIL b2b_lat[%0d] got %0d want %0d", k, lat, model_lat(b)); end
      if (bus.P !== pe) begin n_fail++; $display("FAIL b2b_P[%0d] got %h want %h", k, bus.P, pe); end
      if (bus.exception !== (pe[2*N-1:N] != 0)) begin n_fail++; $display("FAIL b2b_exc[%0d] got %b want %b", k, bus.exception, pe[2*N-1:N] != 0); end
    end
    bus.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    logic [2*N-1:0] p, pe;
    logic exc, bz;
    int lat;
    for (int k = 0; k < 30; k++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 15));
        1: b = 16'($urandom) >> $urandom_range(0, 15);
        2: b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      do_op(a, b, p, exc, lat, bz);
      pe = 32'(a) * 32'(b);
      n_cmp += 4;
      if (p !== pe) begin n_fail++; $display("FAIL rnd_P[%0d] got %h want %h", k, p, pe); end
      if (exc !== (pe[2*N-1:N] != 0)) begin n_fail++; $display("FAIL rnd_exc[%0d] got %b want %b", k, exc, pe[2*N-1:N] != 0); end
      if (lat !== model_lat(b)) begin n_fail++; $display("FAIL rnd_lat[%0d] got %0d want %0d", k, lat, model_lat(b)); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy_done[%0d] got %b want 0", k, bus.busy); end
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_latency();
    test_req_while_busy();
    test_midop_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
